// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
//   Definitions shared by the UART receiver and the UART transmitter.
//   - CLKS_PER_BIT_DEFAULT : the baud constant. Both ends of the link take
//                            their default from here so they cannot drift.
//   - uart_state_e         : frame state encoding.
//   - cnt_width()          : width of a clock counter that holds
//                            CLKS_PER_BIT-1 with one bit of headroom.
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    // System clocks per bit period.
    localparam int CLKS_PER_BIT_DEFAULT = 6950;

    // Frame states. Encodings 6 and 7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        CLEANUP   = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

    // One bit wider than the minimum, so the counter never wraps within a
    // bit period (14 bits for 6950).
    function automatic int cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit) + 1;
    endfunction

endpackage : uart_rx_pkg

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
//   Two-flop synchronizer for an asynchronous serial line. Both flops reset
//   to 1, which is the idle level of the line. A reset therefore never looks
//   like a start bit. Every edge on the line appears on o_Sync two clocks
//   later.
//
//   Ports
//     i_Clock  : system clock, rising edge
//     i_Rst_n  : asynchronous active-low reset
//     i_Async  : asynchronous input (serial line)
//     o_Sync   : synchronized copy of i_Async
// ---------------------------------------------------------------------------
module uart_sync (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Async,
    output logic o_Sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= i_Async;
            sync_q <= meta_q;
        end
    end

    assign o_Sync = sync_q;

endmodule : uart_sync

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   Serial receiver for the 8N1 frames sent by the team's UART transmitter:
//   1 start bit, 8 data bits, 1 stop bit, no parity. The first data bit on
//   the wire lands in index 0 of the [0:7] byte, so a transmitter-to-receiver
//   loopback returns the byte unchanged.
//
//   The receiver oversamples the line at the system clock. A low level in
//   IDLE marks a candidate start bit. The receiver re-checks the line half a
//   bit later and rejects glitches there. It then samples each data bit and
//   the stop bit one full bit period apart, which places every sample at
//   mid-bit.
//
//   Output handshake: there is no ready. o_Rx_DV is high for exactly one
//   cycle when o_Rx_Byte takes a newly received good byte. o_Rx_Byte then
//   holds that byte until the next good frame, so a consumer may capture it
//   on the pulse or later. o_Frame_Err is a separate one-cycle pulse for a
//   frame whose stop bit was sampled low. It is never high together with
//   o_Rx_DV.
//
//   Parameters
//     CLKS_PER_BIT : system clocks per bit period, must be >= 4
//
//   Ports
//     i_Clock     : system clock, rising edge
//     i_Rst_n     : asynchronous active-low reset
//     i_Rx_Serial : asynchronous serial line, idles high
//     o_Rx_DV     : one-cycle pulse, o_Rx_Byte holds a new good byte
//     o_Rx_Byte   : last good byte, index 0 = first data bit received
//     o_Rx_Active : high from start-bit acceptance until the stop sample
//     o_Frame_Err : one-cycle pulse, stop bit sampled low
//     o_Rx_State  : current frame state (debug observation)
// ---------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic        i_Rx_Serial,
    output logic        o_Rx_DV,
    output logic [0:7]  o_Rx_Byte,
    output logic        o_Rx_Active,
    output logic        o_Frame_Err,
    output uart_state_e o_Rx_State
);

    localparam int CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    // ------------------------------------------------------------------
    // Input synchronizer. Every decision below uses rx_sync only.
    // ------------------------------------------------------------------
    logic rx_sync;

    uart_sync u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_Async (i_Rx_Serial),
        .o_Sync  (rx_sync)
    );

    // ------------------------------------------------------------------
    // State and datapath registers, with their next-state values.
    // ------------------------------------------------------------------
    uart_state_e      state,    state_n;
    logic [CNT_W-1:0] count,    count_n;
    logic [2:0]       bit_idx,  bit_idx_n;
    logic [0:7]       shift,    shift_n;
    logic [0:7]       byte_q,   byte_n;
    logic             dv_q,     dv_n;
    logic             ferr_q,   ferr_n;
    logic             active_q, active_n;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state    <= IDLE;
            count    <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            byte_q   <= byte_n;
            dv_q     <= dv_n;
            ferr_q   <= ferr_n;
            active_q <= active_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic. The pulse outputs default low every
    // cycle, so each one lasts exactly one cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        count_n   = count;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        byte_n    = byte_q;
        dv_n      = 1'b0;
        ferr_n    = 1'b0;
        active_n  = active_q;

        case (state)
            IDLE: begin
                count_n   = '0;
                bit_idx_n = '0;
                if (!rx_sync) begin
                    state_n = START;
                end
            end

            // Re-check the start bit at its mid-point. This happens
            // HALF_BIT+1 cycles after the low level was first seen in IDLE.
            START: begin
                if (count < HALF_CNT) begin
                    count_n = count + 1'b1;
                end else begin
                    count_n = '0;
                    if (!rx_sync) begin
                        active_n = 1'b1;
                        state_n  = DATA;
                    end else begin
                        // The low level was a glitch. Nothing is reported.
                        state_n = IDLE;
                    end
                end
            end

            // Each data bit is sampled one full bit period after the
            // previous sample, which lands at mid-bit.
            DATA: begin
                if (count < LAST_CNT) begin
                    count_n = count + 1'b1;
                end else begin
                    count_n          = '0;
                    shift_n[bit_idx] = rx_sync;
                    if (bit_idx < 3'd7) begin
                        bit_idx_n = bit_idx + 1'b1;
                    end else begin
                        bit_idx_n = '0;
                        state_n   = STOP;
                    end
                end
            end

            // Check the stop bit. A good frame publishes the shift
            // register. A bad frame leaves o_Rx_Byte unchanged and waits
            // for the line to return high before it looks for a new start
            // bit.
            STOP: begin
                if (count < LAST_CNT) begin
                    count_n = count + 1'b1;
                end else begin
                    count_n  = '0;
                    active_n = 1'b0;
                    if (rx_sync) begin
                        byte_n  = shift;
                        dv_n    = 1'b1;
                        state_n = CLEANUP;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end

            CLEANUP: begin
                state_n = IDLE;
            end

            // A break (line held low) ends up here and raises only the one
            // error pulse that the STOP state already issued.
            WAIT_HIGH: begin
                if (rx_sync) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n  = IDLE;
                count_n  = '0;
                active_n = 1'b0;
            end
        endcase
    end

    assign o_Rx_DV     = dv_q;
    assign o_Rx_Byte   = byte_q;
    assign o_Rx_Active = active_q;
    assign o_Frame_Err = ferr_q;
    assign o_Rx_State  = state;

endmodule : uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream counterpart of the team's UART transmitter. Consumes the serial line it drives.
- Oversamples the line at the system clock and locates the start bit. Samples each bit at mid-bit and presents a completed byte with a one-cycle valid pulse.
- Same frame format as the transmitter: 1 start bit, 8 data bits, 1 stop bit, no parity, first data bit on the wire landing in index 0 of a [0:7] byte. A transmitter-to-receiver loopback therefore returns the byte unchanged.

Parameters:
- CLKS_PER_BIT, 6950, system clocks per bit period. Must be >= 4.
- HALF_BIT, (CLKS_PER_BIT-1)/2 (derived, integer division), clocks from start detect to start-bit mid-point check.

Ports:
- i_Clock  input  1  system clock, rising edge.
- i_Rst_n  input  1  asynchronous, active-low reset.
- i_Rx_Serial  input  1  asynchronous serial line; idles high.
- o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a newly received good byte.
- o_Rx_Byte  output  [0:7]  last good byte; index 0 = first data bit received.
- o_Rx_Active  output  1  high from start-bit acceptance until end of frame.
- o_Frame_Err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Interface fact: one clock (i_Clock); reset i_Rst_n is asynchronous and active-low.
- Reset values:
  - o_Rx_DV=0, o_Rx_Byte=0, o_Rx_Active=0, o_Frame_Err=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
- Reset asserted mid-frame aborts the frame: no DV, no error pulse, byte output unchanged from the reset value 0.
- Input path:
  - 2-flop synchronizer on i_Rx_Serial; all decisions use the synced value.
  - This adds 2 cycles of latency to every line edge.
- Clock counter width = $clog2(CLKS_PER_BIT)+1 (14 bits at default); must never wrap within a bit period.
- States:
  - IDLE: count=0, bit index=0. Synced line 0 -> START.
  - START: count increments while count < HALF_BIT. At count==HALF_BIT:
    - line still 0 -> count=0, o_Rx_Active=1, go to DATA.
    - line 1 -> glitch; return to IDLE with no output activity.
  - DATA: count increments while count < CLKS_PER_BIT-1. At the terminal count:
    - sample line into shift register index [bit index], count=0.
    - bit index<7 -> index+1; else index=0 and go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample the line.
    - 1 -> o_Rx_Byte loads the shift register, o_Rx_DV=1 for exactly one cycle, go to CLEANUP.
    - 0 -> o_Frame_Err=1 for one cycle, o_Rx_Byte unchanged, go to WAIT_HIGH.
    - o_Rx_Active drops to 0 on this same cycle in both cases.
  - CLEANUP: one cycle, then IDLE. The next start bit is accepted from IDLE onward.
  - WAIT_HIGH: stays until the synced line is 1, then IDLE. A held-low (break) line yields exactly one o_Frame_Err and no further frames.
  - Unused encodings return to IDLE.
- Timing:
  - Start-bit check occurs HALF_BIT+1 cycles after start detect.
  - Each data/stop sample occurs CLKS_PER_BIT cycles after the previous sample, i.e. at the bit mid-point.
- o_Rx_DV and o_Frame_Err are never high together; each is at most one pulse per frame.
- Back-to-back frames (stop bit immediately followed by the next start bit) must be received without loss.

Decomposition:
- Shared include (uart_defs): frame state encodings IDLE/START/DATA/STOP/CLEANUP/WAIT_HIGH, and the CLKS_PER_BIT default, shared with the transmitter so both ends use one baud constant.
- One sub-module, uart_sync: 2-flop synchronizer with async active-low reset to 1.

Test Plan:
- Drive frame for 0xA5 at CLKS_PER_BIT=16 (serial data 1,0,1,0,0,1,0,1) -> one o_Rx_DV pulse, o_Rx_Byte=8'hA5, o_Frame_Err=0, o_Rx_Active high for the frame.
- Loopback to the transmitter, CLKS_PER_BIT=16, bytes 0x00, 0xFF, 0x3C sent back-to-back -> three DV pulses in order with matching bytes.
- Line low for 5 clocks then high (< HALF_BIT+1 after detect) -> no DV, no error, o_Rx_Active stays 0, state back to IDLE.
- Frame 0x55 with stop bit forced 0 -> one o_Frame_Err pulse, no DV, o_Rx_Byte retains previous value. Line then held low 100 clocks -> no further pulses. Line releases, then a valid 0x12 frame -> DV with 8'h12.
- i_Rst_n asserted during data bit 4 of frame 0x81 -> all outputs 0 immediately (asynchronous). After release, a clean 0x81 frame -> DV with 8'h81.
- Default CLKS_PER_BIT=6950, one frame 0xC3 -> DV with 8'hC3, proving the counter holds 6949 without wrap.
